// File: rtl/sr_latch_cmd_arbiter_if.sv
// Command/handshake bundle between requesters, the arbiter and the shared SR latch.
// The master side drives requests and the latch feedback; the slave side is the arbiter.
interface sr_latch_cmd_arbiter_if;
  logic req_a;
  logic op_a;
  logic req_b;
  logic op_b;
  logic gnt_a;
  logic gnt_b;
  logic Q;
  logic S;
  logic R;
  logic busy;
  logic err;

  modport master (
    output req_a, op_a, req_b, op_b, Q,
    input  gnt_a, gnt_b, S, R, busy, err
  );

  modport slave (
    input  req_a, op_a, req_b, op_b, Q,
    output gnt_a, gnt_b, S, R, busy, err
  );
endinterface

// File: rtl/sr_latch_cmd_arbiter.sv
// Round-robin arbiter that shares one SR latch between two requesters.
// It drives clean S/R pulses separated by an all-low gap, then checks Q against the command.
module sr_latch_cmd_arbiter #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_latch_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             prioB_q, prioB_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             gntA_q, gntA_d;
  logic             gntB_q, gntB_d;
  logic             err_q, err_d;
  logic             winB;

  // On a tie, B wins only when A was granted most recently.
  assign winB = bus.req_b & (~bus.req_a | prioB_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    prioB_d = prioB_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    gntA_d  = 1'b0;
    gntB_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          state_d = PULSE;
          cnt_d   = '0;
          op_d    = winB ? bus.op_b : bus.op_a;
          gntA_d  = ~winB;
          gntB_d  = winB;
          prioB_d = ~winB;
          s_d     = op_d;
          r_d     = ~op_d;
        end
      end
      PULSE: begin
        if (cnt_q == PulseLast) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          s_d   = op_q;
          r_d   = ~op_q;
        end
      end
      GAP: begin
        if (cnt_q == GapLast) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = (bus.Q != op_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      prioB_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      gntA_q  <= 1'b0;
      gntB_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      prioB_q <= prioB_d;
      s_q     <= s_d;
      r_q     <= r_d;
      gntA_q  <= gntA_d;
      gntB_q  <= gntB_d;
      err_q   <= err_d;
    end
  end

  assign bus.S     = s_q;
  assign bus.R     = r_q;
  assign bus.gnt_a = gntA_q;
  assign bus.gnt_b = gntB_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sr_latch_cmd_arbiter.sv
// Testbench for sr_latch_cmd_arbiter: a timeline reference model predicts every output,
// and an SR latch model (with an optional stuck-at fault) closes the Q feedback loop.
module tb_sr_latch_cmd_arbiter;
  localparam int PW = 2;
  localparam int GW = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   assertions = 0;
  int   failures   = 0;

  sr_latch_cmd_arbiter_if bus();

  sr_latch_cmd_arbiter #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic latchQ    = 1'b0;
  logic qStuck    = 1'b0;
  logic qStuckVal = 1'b0;
  assign bus.Q = latchQ;

  always @(negedge clk) begin
    if (qStuck) latchQ = qStuckVal;
    else if (bus.S === 1'b1) latchQ = 1'b1;
    else if (bus.R === 1'b1) latchQ = 1'b0;
  end

  // Reference model: each accepted command occupies a fixed window of edges after its acceptance edge.
  int         edgeN    = 0;
  int         acc      = -1000;
  int         nextFree = 0;
  int         mD;
  logic       accWin   = 1'b0;
  logic       accOp    = 1'b0;
  logic       prioB    = 1'b0;
  logic       qBad     = 1'b0;
  logic [5:0] expV     = '0;

  always @(posedge clk) begin
    edgeN++;
    if (rst) begin
      acc      = -1000;
      prioB    = 1'b0;
      nextFree = edgeN + 1;
    end else if (edgeN >= nextFree && (bus.req_a || bus.req_b)) begin
      accWin   = bus.req_b && (!bus.req_a || prioB);
      accOp    = accWin ? bus.op_b : bus.op_a;
      prioB    = !accWin;
      acc      = edgeN;
      nextFree = edgeN + PW + GW + 1;
    end
    mD   = edgeN - acc;
    qBad = (mD == PW + GW) && (latchQ != accOp);
    expV = {mD == 0 && !accWin, mD == 0 && accWin,
            mD >= 0 && mD < PW && accOp, mD >= 0 && mD < PW && !accOp,
            mD >= 0 && mD < PW + GW, qBad};
  end

  task automatic driveReq(input int mode);
    if (bus.gnt_a === 1'b1) bus.req_a = 1'b0;
    else if (!bus.req_a && (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0))) begin
      bus.req_a = 1'b1;
      bus.op_a  = 1'($urandom_range(0, 1));
    end
    if (bus.gnt_b === 1'b1) bus.req_b = 1'b0;
    else if (!bus.req_b && (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0))) begin
      bus.req_b = 1'b1;
      bus.op_b  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      driveReq(0);
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got %b expected 000000", got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_grant: got gnt_a=%b gnt_b=%b expected gnt_a=1 gnt_b=0", bus.gnt_a, bus.gnt_b);
    end
    driveReq(0);
    drain(2 * (PW + GW + 1) + 2);
  endtask

  task automatic test_contention();
    logic [5:0] got;
    int order[$];
    int lastS  = -1;
    int firstR = -1;
    rst = 1'b1;
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * (PW + GW + 1) + 2; k++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== expV) begin
        failures++;
        $display("[TB] FAIL contention_model: cycle %0d got %b expected %b", k, got, expV);
      end
      if (bus.gnt_a === 1'b1) order.push_back(0);
      if (bus.gnt_b === 1'b1) order.push_back(1);
      if (bus.S === 1'b1) lastS = k;
      if (bus.R === 1'b1 && firstR < 0) firstR = k;
      driveReq(0);
    end
    assertions++;
    if (order.size() != 2) begin
      failures++;
      $display("[TB] FAIL contention_order: got %0d grants expected 2", order.size());
    end else if (order[0] != 0 || order[1] != 1) begin
      failures++;
      $display("[TB] FAIL contention_order: got %0d,%0d expected 0,1 (0=A 1=B)", order[0], order[1]);
    end
    assertions++;
    if (firstR - lastS - 1 < 2) begin
      failures++;
      $display("[TB] FAIL contention_gap: got %0d low cycles expected at least 2", firstR - lastS - 1);
    end
    assertions++;
    if (latchQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL contention_final_q: got %b expected 0", latchQ);
    end
  endtask

  task automatic test_single_set();
    logic [5:0] got;
    logic [5:0] tbl [4] = '{6'b101010, 6'b001010, 6'b000010, 6'b000000};
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== tbl[k] || got !== expV) begin
        failures++;
        $display("[TB] FAIL single_set: t+%0d got %b expected %b (model %b)", k + 1, got, tbl[k], expV);
      end
      driveReq(0);
    end
    assertions++;
    if (latchQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_set_q: got %b expected 1", latchQ);
    end
  endtask

  task automatic test_fairness();
    logic [5:0] got;
    int grants[$];
    bus.req_a = 1'b1; bus.op_a = 1'($urandom_range(0, 1));
    bus.req_b = 1'b1; bus.op_b = 1'($urandom_range(0, 1));
    for (int k = 0; k < 6 * (PW + GW + 1) + 8 && grants.size() < 6; k++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== expV) begin
        failures++;
        $display("[TB] FAIL fairness_model: cycle %0d got %b expected %b", k, got, expV);
      end
      if (bus.gnt_a === 1'b1) grants.push_back(0);
      if (bus.gnt_b === 1'b1) grants.push_back(1);
      driveReq(2);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    assertions++;
    if (grants.size() != 6) begin
      failures++;
      $display("[TB] FAIL fairness_count: got %0d grants expected 6", grants.size());
    end
    for (int i = 1; i < grants.size(); i++) begin
      assertions++;
      if (grants[i] == grants[i-1]) begin
        failures++;
        $display("[TB] FAIL fairness_alternate: grant %0d got side %0d expected side %0d", i, grants[i], 1 - grants[i-1]);
      end
    end
    drain(PW + GW + 2);
  endtask

  task automatic test_q_check();
    logic [5:0] got;
    qStuck = 1'b1; qStuckVal = 1'b0;
    bus.req_b = 1'b1; bus.op_b = 1'b1;
    for (int k = 1; k <= PW + GW + 3; k++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== expV) begin
        failures++;
        $display("[TB] FAIL qcheck_model: t+%0d got %b expected %b", k, got, expV);
      end
      assertions++;
      if (bus.err !== (k == PW + GW + 1)) begin
        failures++;
        $display("[TB] FAIL qcheck_err: t+%0d got %b expected %b", k, bus.err, k == PW + GW + 1);
      end
      if (k == PW + GW + 2) begin
        assertions++;
        if (bus.gnt_a !== 1'b1) begin
          failures++;
          $display("[TB] FAIL qcheck_next: got gnt_a=%b expected 1", bus.gnt_a);
        end
      end
      driveReq(0);
      if (k == 2) begin
        bus.req_a = 1'b1; bus.op_a = 1'b0;
      end
    end
    drain(PW + GW + 2);
    qStuck = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    logic [5:0] got;
    bus.req_a = 1'b1; bus.op_a = 1'b1;
    @(negedge clk);
    assertions++;
    if (bus.S !== 1'b1 || bus.gnt_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_start: got S=%b gnt_a=%b expected 1,1", bus.S, bus.gnt_a);
    end
    driveReq(0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst = 1'b0;
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== 6'b0 || expV !== 6'b0) begin
        failures++;
        $display("[TB] FAIL rstmid_quiet: cycle %0d got %b expected 000000 (model %b)", k, got, expV);
      end
    end
    bus.req_a = 1'b1; bus.op_a = 1'b0;
    bus.req_b = 1'b1; bus.op_b = 1'b1;
    @(negedge clk);
    assertions++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_priority: got gnt_a=%b gnt_b=%b expected 1,0", bus.gnt_a, bus.gnt_b);
    end
    driveReq(0);
    drain(2 * (PW + GW + 1) + 2);
  endtask

  task automatic test_random();
    logic [5:0] got;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      got = {bus.gnt_a, bus.gnt_b, bus.S, bus.R, bus.busy, bus.err};
      assertions++;
      if (got !== expV) begin
        failures++;
        $display("[TB] FAIL random_model: cycle %0d got %b expected %b", k, got, expV);
      end
      assertions++;
      if (((bus.S & bus.R) | (bus.gnt_a & bus.gnt_b)) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random_invariant: cycle %0d got S=%b R=%b gnt_a=%b gnt_b=%b expected no overlap",
                 k, bus.S, bus.R, bus.gnt_a, bus.gnt_b);
      end
      driveReq(1);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) begin
        qStuck    = ~qStuck;
        qStuckVal = 1'($urandom_range(0, 1));
      end
    end
    rst = 1'b0;
    qStuck = 1'b0;
    drain(2 * (PW + GW + 1) + 2);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_a = 1'b0; bus.op_a = 1'b0;
    bus.req_b = 1'b0; bus.op_b = 1'b0;
    test_reset();
    test_contention();
    test_single_set();
    test_fairness();
    test_q_check();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
